// File: rtl/dcache_miss_ctrl.sv
// Data-cache miss controller: on a load/store miss it freezes the pipeline,
// writes the dirty victim block back to memory (if needed), fetches the
// missing block as a burst of beats and strobes the refill into the cache.
// Optional feature: define DCACHE_MISS_CNT_EN to add a saturating 32-bit
// miss counter on o_miss_count.
module dcache_miss_ctrl #(
    parameter int unsigned ADDR_WIDTH = 64,
    parameter int unsigned SET_WIDTH  = 512,
    parameter int unsigned BEAT_WIDTH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_arst_n,
    input  logic                  i_mem_access,
    input  logic                  i_hit,
    input  logic                  i_dirty,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [ADDR_WIDTH-1:0] i_addr_wb,
    input  logic [SET_WIDTH-1:0]  i_victim_block,
    output logic                  o_stall,
    output logic                  o_block_we,
    output logic [SET_WIDTH-1:0]  o_data_block,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_req_we,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    output logic                  o_mem_wvalid,
    input  logic                  i_mem_wready,
    output logic [BEAT_WIDTH-1:0] o_mem_wdata,
    input  logic                  i_mem_rvalid,
    input  logic [BEAT_WIDTH-1:0] i_mem_rdata
`ifdef DCACHE_MISS_CNT_EN
    ,
    output logic [31:0]           o_miss_count
`endif
);

    localparam int unsigned BEATS = SET_WIDTH / BEAT_WIDTH;
    localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned OFF_W = $clog2(SET_WIDTH / 8);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'((64'd1 << OFF_W) - 64'd1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WB_REQ,
        S_WB_DATA,
        S_RD_REQ,
        S_RD_DATA,
        S_REFILL
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [ADDR_WIDTH-1:0] wb_addr_q, wb_addr_d;
    logic [SET_WIDTH-1:0]  victim_q, victim_d;
    logic [SET_WIDTH-1:0]  fill_q, fill_d;
    logic                  miss_c;

    assign miss_c = i_mem_access & ~i_hit;

    // State and datapath registers; reset abandons any transfer in flight.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            fill_addr_q <= '0;
            wb_addr_q   <= '0;
            victim_q    <= '0;
            fill_q      <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            fill_addr_q <= fill_addr_d;
            wb_addr_q   <= wb_addr_d;
            victim_q    <= victim_d;
            fill_q      <= fill_d;
        end
    end

    // Next-state, capture/fill updates and state-decoded outputs.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        fill_addr_d     = fill_addr_q;
        wb_addr_d       = wb_addr_q;
        victim_d        = victim_q;
        fill_d          = fill_q;
        o_stall         = 1'b0;
        o_block_we      = 1'b0;
        o_data_block    = '0;
        o_mem_req_valid = 1'b0;
        o_mem_req_we    = 1'b0;
        o_mem_req_addr  = '0;
        o_mem_wvalid    = 1'b0;
        o_mem_wdata     = '0;

        case (state_q)
            S_IDLE: begin
                // Stall is qualified with reset so every output reads 0 while held in reset.
                o_stall = miss_c & i_arst_n;
                if (miss_c) begin
                    fill_addr_d = i_addr & ~OFF_MASK;
                    wb_addr_d   = i_addr_wb;
                    victim_d    = i_victim_block;
                    cnt_d       = '0;
                    state_d     = i_dirty ? S_WB_REQ : S_RD_REQ;
                end
            end
            S_WB_REQ: begin
                o_stall         = 1'b1;
                o_mem_req_valid = 1'b1;
                o_mem_req_we    = 1'b1;
                o_mem_req_addr  = wb_addr_q;
                if (i_mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WB_DATA;
                end
            end
            S_WB_DATA: begin
                o_stall      = 1'b1;
                o_mem_wvalid = 1'b1;
                o_mem_wdata  = victim_q[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH];
                if (i_mem_wready) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_RD_REQ;
                    end
                end
            end
            S_RD_REQ: begin
                o_stall         = 1'b1;
                o_mem_req_valid = 1'b1;
                o_mem_req_addr  = fill_addr_q;
                if (i_mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_RD_DATA;
                end
            end
            S_RD_DATA: begin
                o_stall = 1'b1;
                if (i_mem_rvalid) begin
                    fill_d[int'(cnt_q)*BEAT_WIDTH +: BEAT_WIDTH] = i_mem_rdata;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BEAT) begin
                        state_d = S_REFILL;
                    end
                end
            end
            S_REFILL: begin
                o_stall      = 1'b1;
                o_block_we   = 1'b1;
                o_data_block = fill_q;
                state_d      = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

`ifdef DCACHE_MISS_CNT_EN
    logic [31:0] miss_cnt_q, miss_cnt_d;

    // Count every departure from IDLE, saturating at all-ones.
    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if ((state_q == S_IDLE) && miss_c && (miss_cnt_q != 32'hFFFF_FFFF)) begin
            miss_cnt_d = miss_cnt_q + 32'd1;
        end
    end

    // Miss counter register.
    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign o_miss_count = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_miss_ctrl.sv
// Scoreboard bench for dcache_miss_ctrl: stimulus pushes expected memory
// requests, write beats and refill blocks; a negedge monitor pops/compares.
// Build with DCACHE_MISS_CNT_EN defined to also cover the miss counter.
module tb_dcache_miss_ctrl;

    localparam int unsigned AW = 64;
    localparam int unsigned SW = 512;
    localparam int unsigned BW = 64;
    localparam int unsigned NB = 8;

    localparam int PH_IDLE = 0;
    localparam int PH_HIT  = 1;
    localparam int PH_MISS = 2;
    localparam int PH_RST  = 3;
    localparam int PH_CNT  = 4;
    localparam int PH_DONE = 5;

    logic          i_clk;
    logic          i_arst_n;
    logic          i_mem_access;
    logic          i_hit;
    logic          i_dirty;
    logic [AW-1:0] i_addr;
    logic [AW-1:0] i_addr_wb;
    logic [SW-1:0] i_victim_block;
    logic          o_stall;
    logic          o_block_we;
    logic [SW-1:0] o_data_block;
    logic          o_mem_req_valid;
    logic          i_mem_req_ready;
    logic          o_mem_req_we;
    logic [AW-1:0] o_mem_req_addr;
    logic          o_mem_wvalid;
    logic          i_mem_wready;
    logic [BW-1:0] o_mem_wdata;
    logic          i_mem_rvalid;
    logic [BW-1:0] i_mem_rdata;
`ifdef DCACHE_MISS_CNT_EN
    logic [31:0]   o_miss_count;
    logic [31:0]   exp_miss;
`endif

    dcache_miss_ctrl #(
        .ADDR_WIDTH(AW),
        .SET_WIDTH (SW),
        .BEAT_WIDTH(BW)
    ) dut (
        .i_clk          (i_clk),
        .i_arst_n       (i_arst_n),
        .i_mem_access   (i_mem_access),
        .i_hit          (i_hit),
        .i_dirty        (i_dirty),
        .i_addr         (i_addr),
        .i_addr_wb      (i_addr_wb),
        .i_victim_block (i_victim_block),
        .o_stall        (o_stall),
        .o_block_we     (o_block_we),
        .o_data_block   (o_data_block),
        .o_mem_req_valid(o_mem_req_valid),
        .i_mem_req_ready(i_mem_req_ready),
        .o_mem_req_we   (o_mem_req_we),
        .o_mem_req_addr (o_mem_req_addr),
        .o_mem_wvalid   (o_mem_wvalid),
        .i_mem_wready   (i_mem_wready),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_rvalid   (i_mem_rvalid),
        .i_mem_rdata    (i_mem_rdata)
`ifdef DCACHE_MISS_CNT_EN
        ,
        .o_miss_count   (o_miss_count)
`endif
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Scoreboard queues filled by stimulus, drained by the monitor.
    logic [AW:0]   exp_req_q[$];
    logic [BW-1:0] exp_w_q[$];
    logic [SW-1:0] exp_blk_q[$];

    int phase   = PH_RST;
    int tmo_cnt = 0;
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compares DUT behaviour against the queued expectations.
    logic          hold_pend = 1'b0;
    logic [BW-1:0] hold_data = '0;
    logic          prev_bwe  = 1'b0;
    always @(negedge i_clk) begin
        if (!i_arst_n) begin
            hold_pend = 1'b0;
            prev_bwe  = 1'b0;
            check("reset_ctrl_outs", SW'({o_stall, o_mem_req_valid, o_mem_req_we, o_mem_wvalid, o_block_we}), SW'(0));
            check("reset_addr_wdata", SW'({o_mem_req_addr, o_mem_wdata}), SW'(0));
            check("reset_data_block", o_data_block, SW'(0));
`ifdef DCACHE_MISS_CNT_EN
            check("reset_miss_count", SW'(o_miss_count), SW'(0));
`endif
        end else begin
            if (hold_pend) begin
                check("wvalid_held", SW'(o_mem_wvalid), SW'(1));
                check("wdata_held", SW'(o_mem_wdata), SW'(hold_data));
            end
            hold_pend = o_mem_wvalid && !i_mem_wready;
            hold_data = o_mem_wdata;

            if (o_mem_req_valid && i_mem_req_ready) begin
                if (exp_req_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_req: got we=%0b addr=%0h expected none", o_mem_req_we, o_mem_req_addr);
                end else begin
                    check("mem_req", SW'({o_mem_req_we, o_mem_req_addr}), SW'(exp_req_q.pop_front()));
                end
            end
            if (o_mem_wvalid && i_mem_wready) begin
                if (exp_w_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_wbeat: got %0h expected none", o_mem_wdata);
                end else begin
                    check("wdata_beat", SW'(o_mem_wdata), SW'(exp_w_q.pop_front()));
                end
            end
            if (o_block_we) begin
                check("block_we_single", SW'(prev_bwe), SW'(0));
                if (exp_blk_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_refill: got %0h expected none", o_data_block);
                end else begin
                    check("refill_block", o_data_block, exp_blk_q.pop_front());
                end
            end
            prev_bwe = o_block_we;

            case (phase)
                PH_HIT:  check("hit_no_stall_no_req", SW'({o_stall, o_mem_req_valid}), SW'(0));
                PH_MISS: check("miss_stall", SW'(o_stall), SW'(1));
`ifdef DCACHE_MISS_CNT_EN
                PH_CNT:  check("miss_count", SW'(o_miss_count), SW'(exp_miss));
`endif
                PH_DONE: begin
                    check("queues_drained", SW'(exp_req_q.size() + exp_w_q.size() + exp_blk_q.size()), SW'(0));
                    check("no_timeouts", SW'(tmo_cnt), SW'(0));
                    $display("%0d/%0d checks passed", n_pass, n_checks);
                    $finish;
                end
                default: ;
            endcase
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wait_req(input int delay);
        int t = 0;
        while (!o_mem_req_valid && t < 50) begin
            tick();
            t++;
        end
        if (!o_mem_req_valid) begin
            tmo_cnt++;
            $display("note: timeout waiting for request valid");
        end
        repeat (delay) tick();
        i_mem_req_ready = 1'b1;
        tick();
        i_mem_req_ready = 1'b0;
    endtask

    // Write-beat sink; optionally pulses reset once abort_after beats have gone.
    task automatic wb_data(input bit toggle, input int abort_after, output bit aborted);
        int acc = 0;
        int t = 0;
        bit a;
        aborted = 1'b0;
        i_mem_rvalid = 1'b1;
        i_mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
        while (acc < NB && t < 100) begin
            i_mem_wready = toggle ? (t % 2 == 0) : 1'b1;
            #1;
            a = o_mem_wvalid && i_mem_wready;
            tick();
            t++;
            if (a) acc++;
            if (abort_after != 0 && acc == abort_after) begin
                i_mem_wready = 1'b0;
                i_mem_rvalid = 1'b0;
                i_arst_n     = 1'b0;
                phase        = PH_RST;
                exp_req_q.delete();
                exp_w_q.delete();
                exp_blk_q.delete();
                i_mem_access = 1'b0;
                tick();
                tick();
                i_arst_n = 1'b1;
                phase    = PH_IDLE;
                aborted  = 1'b1;
                return;
            end
        end
        if (acc != NB) begin
            tmo_cnt++;
            $display("note: timeout in write-back data phase");
        end
        i_mem_wready = 1'b0;
        i_mem_rvalid = 1'b0;
    endtask

    task automatic rd_data(input logic [SW-1:0] fill);
        i_mem_access = 1'b0;
        i_mem_wready = 1'b1;
        for (int k = 0; k < NB; k++) begin
            if (k == 4) begin
                i_mem_rvalid = 1'b0;
                tick();
            end
            i_mem_rvalid = 1'b1;
            i_mem_rdata  = fill[k*BW +: BW];
            tick();
        end
        i_mem_rvalid = 1'b0;
        i_mem_wready = 1'b0;
    endtask

    task automatic wait_refill();
        int t = 0;
        while (!o_block_we && t < 20) begin
            tick();
            t++;
        end
        if (!o_block_we) begin
            tmo_cnt++;
            $display("note: timeout waiting for refill strobe");
        end
        tick();
        phase = PH_IDLE;
    endtask

    task automatic do_miss(input logic [AW-1:0] addr, input logic [AW-1:0] exp_addr,
                           input logic [AW-1:0] wb, input bit dirty,
                           input logic [SW-1:0] victim, input logic [SW-1:0] fill,
                           input int delay, input bit toggle, input int abort_after);
        bit aborted;
        if (dirty) begin
            exp_req_q.push_back({1'b1, wb});
            for (int k = 0; k < NB; k++) exp_w_q.push_back(victim[k*BW +: BW]);
        end
        exp_req_q.push_back({1'b0, exp_addr});
        exp_blk_q.push_back(fill);
        i_mem_access   = 1'b1;
        i_hit          = 1'b0;
        i_dirty        = dirty;
        i_addr         = addr;
        i_addr_wb      = wb;
        i_victim_block = victim;
        phase          = PH_MISS;
        tick();
        // Keep a miss pending with garbage; it must be ignored outside IDLE.
        i_addr         = ~addr;
        i_addr_wb      = ~wb;
        i_victim_block = ~victim;
        i_dirty        = ~dirty;
        if (dirty) begin
            wait_req(delay);
            wb_data(toggle, abort_after, aborted);
            if (aborted) return;
        end
        wait_req(delay);
        rd_data(fill);
        wait_refill();
    endtask

    logic [SW-1:0] fill_a, fill_b, fill_c, vic_a, vic_b;

    initial begin
        i_arst_n = 1'b0;
        i_mem_access = 1'b0; i_hit = 1'b0; i_dirty = 1'b0;
        i_addr = '0; i_addr_wb = '0; i_victim_block = '0;
        i_mem_req_ready = 1'b0; i_mem_wready = 1'b0;
        i_mem_rvalid = 1'b0; i_mem_rdata = '0;
        for (int k = 0; k < NB; k++) begin
            fill_a[k*BW +: BW] = BW'(k + 1) * 64'h1111_1111_1111_1111;
            fill_b[k*BW +: BW] = 64'hA5A5_0000_0000_00A0 + BW'(k);
            fill_c[k*BW +: BW] = 64'hC0DE_0000_0000_0000 + BW'(k << 8);
            vic_a[k*BW +: BW]  = BW'(k);
            vic_b[k*BW +: BW]  = 64'hDEAD_0000 + BW'(k);
        end
        phase = PH_RST;
        repeat (3) tick();
        i_arst_n = 1'b1;
        phase = PH_IDLE;
        tick();

        // Hits never stall or request memory.
        phase = PH_HIT;
        i_mem_access = 1'b1; i_hit = 1'b1; i_dirty = 1'b1;
        i_addr = 64'h5000; i_mem_req_ready = 1'b1;
        repeat (3) tick();
        i_mem_access = 1'b0; i_hit = 1'b0; i_mem_req_ready = 1'b0;
        phase = PH_IDLE;
        tick();

        // Clean miss, request ready after 3 cycles.
        do_miss(64'h1040, 64'h1040, 64'h0, 1'b0, '0, fill_a, 3, 1'b0, 0);
        // Dirty miss with unaligned access address.
        do_miss(64'h2_5078, 64'h2_5040, 64'h2000, 1'b1, vic_a, fill_b, 1, 1'b0, 0);
        // Dirty miss with toggling write ready.
        do_miss(64'h7FC0, 64'h7FC0, 64'h9100, 1'b1, vic_b, fill_c, 0, 1'b1, 0);
`ifdef DCACHE_MISS_CNT_EN
        exp_miss = 32'd3;
        phase = PH_CNT;
        tick();
        phase = PH_IDLE;
`endif
        // Reset after beat 3 of the write-back, then a clean miss right away.
        do_miss(64'h8000, 64'h8000, 64'h4000, 1'b1, vic_a, fill_a, 0, 1'b0, 4);
        do_miss(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 64'h0, 1'b0, '0, fill_b, 0, 1'b0, 0);
`ifdef DCACHE_MISS_CNT_EN
        exp_miss = 32'd1;
        phase = PH_CNT;
        tick();
        phase = PH_IDLE;
        force dut.miss_cnt_q = 32'hFFFF_FFFF;
        tick();
        release dut.miss_cnt_q;
        do_miss(64'h3000, 64'h3000, 64'h0, 1'b0, '0, fill_c, 0, 1'b0, 0);
        exp_miss = 32'hFFFF_FFFF;
        phase = PH_CNT;
        tick();
        phase = PH_IDLE;
`endif
        tick();
        phase = PH_DONE;
        repeat (5) tick();
    end

endmodule
